// File: rtl/axil_addr_router_if.sv
// AXI4-Lite 1-to-N router bus bundle: upstream master port (s_*) plus the
// broadcast/per-slave downstream port (m_*). slave = router view, master = environment view.
interface axil_addr_router_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();
  logic [ADDR_WIDTH-1:0]                  s_awaddr;
  logic                                   s_awvalid, s_awready;
  logic [DATA_WIDTH-1:0]                  s_wdata;
  logic [DATA_WIDTH/8-1:0]                s_wstrb;
  logic                                   s_wvalid, s_wready;
  logic [1:0]                             s_bresp;
  logic                                   s_bvalid, s_bready;
  logic [ADDR_WIDTH-1:0]                  s_araddr;
  logic                                   s_arvalid, s_arready;
  logic [DATA_WIDTH-1:0]                  s_rdata;
  logic [1:0]                             s_rresp;
  logic                                   s_rvalid, s_rready;

  logic [ADDR_WIDTH-1:0]                  m_awaddr, m_araddr;
  logic [DATA_WIDTH-1:0]                  m_wdata;
  logic [DATA_WIDTH/8-1:0]                m_wstrb;
  logic [NUM_SLAVES-1:0]                  m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [NUM_SLAVES-1:0]                  m_awready, m_wready, m_bvalid, m_arready, m_rvalid;
  logic [NUM_SLAVES-1:0][1:0]             m_bresp, m_rresp;
  logic [NUM_SLAVES-1:0][DATA_WIDTH-1:0]  m_rdata;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready, s_araddr, s_arvalid, s_rready,
           m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rresp, m_rdata,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
           m_awaddr, m_wdata, m_wstrb, m_araddr, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready, s_araddr, s_arvalid, s_rready,
           m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rresp, m_rdata,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready, s_rdata, s_rresp, s_rvalid,
           m_awaddr, m_wdata, m_wstrb, m_araddr, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready
  );
endinterface

// File: rtl/axil_addr_router.sv
// AXI4-Lite 1-to-N address router: single outstanding transaction, base/mask
// decode, DECERR on miss, SLVERR on slave timeout, saturating error counters.
module axil_addr_router #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {NUM_SLAVES{32'hFFFF_F000}},
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  axil_addr_router_if.slave   bus,
  input  logic                clear_stats,
  output logic                busy,
  output logic [15:0]         decerr_count,
  output logic [15:0]         timeout_count
);
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SB = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, W_ISSUE, W_RESP, W_RET, R_ISSUE, R_RESP, R_RET} state_t;
  state_t state, state_n;

  // {hit, index}; iterating downwards lets the lowest hitting index win
  function automatic logic [SW:0] decode(input logic [ADDR_WIDTH-1:0] a);
    logic [SW:0] r;
    r = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((a & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]))
        r = {1'b1, SW'(i)};
    return r;
  endfunction

  logic [SW:0]            aw_dec, ar_dec;
  logic [SW-1:0]          sel;
  logic [NUM_SLAVES-1:0]  sel_oh;
  logic                   aw_pend, w_pend, ar_pend, last_grant_rd;
  logic [TW-1:0]          tcnt;
  logic [ADDR_WIDTH-1:0]  awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0]  wdata_q, rdata_q;
  logic [SB-1:0]          wstrb_q;
  logic [1:0]             bresp_q, rresp_q;
  logic [15:0]            decerr_q, timeout_q, decerr_n, timeout_n;
  logic                   wr_req, rd_req, conflict, idle_ok, grant_w, grant_r;
  logic                   aw_done, w_done, ar_done, tmo;
  logic                   w_iss_to, w_rsp_to, r_iss_to, r_rsp_to, to_hit, dec_inc;

  assign aw_dec   = decode(bus.s_awaddr);
  assign ar_dec   = decode(bus.s_araddr);
  assign wr_req   = bus.s_awvalid && bus.s_wvalid;
  assign rd_req   = bus.s_arvalid;
  assign conflict = wr_req && rd_req;
  assign idle_ok  = (state == IDLE) && !rst;
  assign grant_w  = idle_ok && wr_req && (!rd_req || last_grant_rd);
  assign grant_r  = idle_ok && rd_req && (!wr_req || !last_grant_rd);

  assign sel_oh   = NUM_SLAVES'(1) << sel;
  assign aw_done  = !aw_pend || bus.m_awready[sel];
  assign w_done   = !w_pend  || bus.m_wready[sel];
  assign ar_done  = !ar_pend || bus.m_arready[sel];
  assign tmo      = (tcnt == TW'(TIMEOUT_CYCLES - 1));

  // a finishing handshake on the last allowed cycle takes precedence over the timeout
  assign w_iss_to = (state == W_ISSUE) && tmo && !(aw_done && w_done);
  assign w_rsp_to = (state == W_RESP)  && tmo && !bus.m_bvalid[sel];
  assign r_iss_to = (state == R_ISSUE) && tmo && !ar_done;
  assign r_rsp_to = (state == R_RESP)  && tmo && !bus.m_rvalid[sel];
  assign to_hit   = w_iss_to || w_rsp_to || r_iss_to || r_rsp_to;
  assign dec_inc  = (grant_w && !aw_dec[SW]) || (grant_r && !ar_dec[SW]);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (grant_w)      state_n = aw_dec[SW] ? W_ISSUE : W_RET;
        else if (grant_r) state_n = ar_dec[SW] ? R_ISSUE : R_RET;
      end
      W_ISSUE: if (aw_done && w_done) state_n = W_RESP; else if (tmo) state_n = W_RET;
      W_RESP:  if (bus.m_bvalid[sel] || tmo) state_n = W_RET;
      W_RET:   if (bus.s_bready) state_n = IDLE;
      R_ISSUE: if (ar_done) state_n = R_RESP; else if (tmo) state_n = R_RET;
      R_RESP:  if (bus.m_rvalid[sel] || tmo) state_n = R_RET;
      R_RET:   if (bus.s_rready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel <= '0; aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
      last_grant_rd <= 1'b1; tcnt <= '0;
      awaddr_q <= '0; araddr_q <= '0; wdata_q <= '0; wstrb_q <= '0;
      rdata_q <= '0; bresp_q <= 2'b00; rresp_q <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (grant_w) begin
            awaddr_q <= bus.s_awaddr; wdata_q <= bus.s_wdata; wstrb_q <= bus.s_wstrb;
            sel      <= aw_dec[SW-1:0];
            aw_pend  <= aw_dec[SW];
            w_pend   <= aw_dec[SW];
            bresp_q  <= aw_dec[SW] ? 2'b00 : 2'b11;
            // arbitration history only moves on real conflicts
            if (conflict) last_grant_rd <= 1'b0;
          end else if (grant_r) begin
            araddr_q <= bus.s_araddr;
            sel      <= ar_dec[SW-1:0];
            ar_pend  <= ar_dec[SW];
            rresp_q  <= ar_dec[SW] ? 2'b00 : 2'b11;
            rdata_q  <= '0;
            if (conflict) last_grant_rd <= 1'b1;
          end
        end
        W_ISSUE: begin
          tcnt <= tcnt + 1'b1;
          if (aw_pend && bus.m_awready[sel]) aw_pend <= 1'b0;
          if (w_pend && bus.m_wready[sel])   w_pend  <= 1'b0;
          if (w_iss_to) begin aw_pend <= 1'b0; w_pend <= 1'b0; bresp_q <= 2'b10; end
        end
        W_RESP: begin
          tcnt <= tcnt + 1'b1;
          if (bus.m_bvalid[sel]) bresp_q <= bus.m_bresp[sel];
          else if (tmo)          bresp_q <= 2'b10;
        end
        R_ISSUE: begin
          tcnt <= tcnt + 1'b1;
          if (ar_pend && bus.m_arready[sel]) ar_pend <= 1'b0;
          if (r_iss_to) begin ar_pend <= 1'b0; rresp_q <= 2'b10; rdata_q <= '0; end
        end
        R_RESP: begin
          tcnt <= tcnt + 1'b1;
          if (bus.m_rvalid[sel]) begin
            rdata_q <= bus.m_rdata[sel]; rresp_q <= bus.m_rresp[sel];
          end else if (tmo) begin
            rdata_q <= '0; rresp_q <= 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    decerr_n  = decerr_q;
    timeout_n = timeout_q;
    if (clear_stats) begin
      decerr_n  = '0;
      timeout_n = '0;
    end else begin
      if (dec_inc && decerr_q != 16'hFFFF)  decerr_n  = decerr_q + 16'd1;
      if (to_hit && timeout_q != 16'hFFFF)  timeout_n = timeout_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      decerr_q  <= '0;
      timeout_q <= '0;
    end else begin
      decerr_q  <= decerr_n;
      timeout_q <= timeout_n;
    end
  end

  assign bus.s_awready = grant_w;
  assign bus.s_wready  = grant_w;
  assign bus.s_arready = grant_r;
  assign bus.s_bvalid  = (state == W_RET);
  assign bus.s_bresp   = bresp_q;
  assign bus.s_rvalid  = (state == R_RET);
  assign bus.s_rresp   = rresp_q;
  assign bus.s_rdata   = rdata_q;

  assign bus.m_awaddr  = awaddr_q;
  assign bus.m_wdata   = wdata_q;
  assign bus.m_wstrb   = wstrb_q;
  assign bus.m_araddr  = araddr_q;
  assign bus.m_awvalid = aw_pend ? sel_oh : '0;
  assign bus.m_wvalid  = w_pend  ? sel_oh : '0;
  assign bus.m_arvalid = ar_pend ? sel_oh : '0;
  assign bus.m_bready  = (state == W_RESP) ? sel_oh : '0;
  assign bus.m_rready  = (state == R_RESP) ? sel_oh : '0;

  assign busy          = (state != IDLE);
  assign decerr_count  = decerr_q;
  assign timeout_count = timeout_q;
endmodule

// File: tb/tb_axil_addr_router.sv
// Directed bench for axil_addr_router: queue scoreboard on the upstream
// response channels plus inline timing/counter checks.
module tb_axil_addr_router;
  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_stats;
  logic        busy;
  logic [15:0] decerr_count, timeout_count;

  always #5 clk = ~clk;

  axil_addr_router_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axil_addr_router #(.NUM_SLAVES(NS), .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .clear_stats(clear_stats),
    .busy(busy), .decerr_count(decerr_count), .timeout_count(timeout_count)
  );

  // per-slave behaviour knobs
  logic [NS-1:0] aw_en;
  int            bdly [NS];
  int            rdly [NS];

  for (genvar g = 0; g < NS; g++) begin : slv
    logic aw_got, w_got, bv, rv, aw_hs, w_hs, ar_hs;
    int   bcnt, rcnt;
    assign aw_hs = bus.m_awvalid[g] && bus.m_awready[g];
    assign w_hs  = bus.m_wvalid[g]  && bus.m_wready[g];
    assign ar_hs = bus.m_arvalid[g] && bus.m_arready[g];
    assign bus.m_awready[g] = aw_en[g];
    assign bus.m_wready[g]  = 1'b1;
    assign bus.m_arready[g] = 1'b1;
    assign bus.m_bvalid[g]  = bv;
    assign bus.m_bresp[g]   = 2'b00;
    assign bus.m_rvalid[g]  = rv;
    assign bus.m_rresp[g]   = 2'b00;
    assign bus.m_rdata[g]   = (g == 1) ? 32'h1234_5678 : (32'hA0A0_0000 + g);
    always @(posedge clk) begin
      if (rst) begin
        aw_got <= 1'b0; w_got <= 1'b0; bv <= 1'b0; rv <= 1'b0; bcnt <= 0; rcnt <= 0;
      end else begin
        if (bv && bus.m_bready[g]) bv <= 1'b0;
        if (rv && bus.m_rready[g]) rv <= 1'b0;
        if ((aw_got || aw_hs) && (w_got || w_hs)) begin
          aw_got <= 1'b0; w_got <= 1'b0;
          if (bdly[g] == 0) bv <= 1'b1; else bcnt <= bdly[g];
        end else begin
          if (aw_hs) aw_got <= 1'b1;
          if (w_hs)  w_got  <= 1'b1;
        end
        if (bcnt > 0) begin bcnt <= bcnt - 1; if (bcnt == 1) bv <= 1'b1; end
        if (ar_hs) begin
          if (rdly[g] == 0) rv <= 1'b1; else rcnt <= rdly[g];
        end
        if (rcnt > 0) begin rcnt <= rcnt - 1; if (rcnt == 1) rv <= 1'b1; end
      end
    end
  end

  typedef struct {bit is_rd; logic [1:0] resp; logic [31:0] data;} exp_t;
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push(input bit r, input logic [1:0] resp, input logic [31:0] d);
    exp_t e;
    e.is_rd = r; e.resp = resp; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic sb_check(input bit r, input logic [1:0] resp, input logic [31:0] d);
    exp_t e;
    if (sbq.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_unexpected: got rd=%0d resp=%b want no response", r, resp);
    end else begin
      e = sbq.pop_front();
      chk("sb_kind", 32'(r), 32'(e.is_rd));
      chk("sb_resp", 32'(resp), 32'(e.resp));
      if (r) chk("sb_rdata", d, e.data);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && bus.s_bvalid && bus.s_bready) sb_check(1'b0, bus.s_bresp, 32'h0);
      if (!rst && bus.s_rvalid && bus.s_rready) sb_check(1'b1, bus.s_rresp, bus.s_rdata);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                    input logic [1:0] er, output int lat,
                    output logic [3:0] v1, output logic [3:0] vend, output logic [3:0] seen);
    int n;
    push(1'b0, er, 32'h0);
    @(posedge clk); #1;
    bus.s_awaddr = a; bus.s_wdata = d; bus.s_wstrb = st;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.s_awready && n < 50) begin @(negedge clk); n++; end
    chk("wr_grant", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
    lat = 0; seen = '0; v1 = '0;
    do begin
      @(negedge clk); lat++;
      seen |= bus.m_awvalid;
      if (lat == 1) v1 = bus.m_awvalid;
    end while (!bus.s_bvalid && lat < 100);
    vend = bus.m_awvalid;
    chk("wr_bvalid", 32'(bus.s_bvalid), 32'd1);
    @(posedge clk);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er,
                    output int lat, output logic [3:0] v1, output logic [3:0] seen);
    int n;
    push(1'b1, er, ed);
    @(posedge clk); #1;
    bus.s_araddr = a; bus.s_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.s_arready && n < 50) begin @(negedge clk); n++; end
    chk("rd_grant", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0;
    lat = 0; seen = '0; v1 = '0;
    do begin
      @(negedge clk); lat++;
      seen |= bus.m_arvalid;
      if (lat == 1) v1 = bus.m_arvalid;
    end while (!bus.s_rvalid && lat < 100);
    chk("rd_rvalid", 32'(bus.s_rvalid), 32'd1);
    @(posedge clk);
  endtask

  // simultaneous AW+W and AR; write goes to slave 2, read to slave 1
  task automatic pair(input bit w_first);
    int   n;
    logic gw, gr;
    if (w_first) begin push(1'b0, 2'b00, 32'h0); push(1'b1, 2'b00, 32'h1234_5678); end
    else         begin push(1'b1, 2'b00, 32'h1234_5678); push(1'b0, 2'b00, 32'h0); end
    @(posedge clk); #1;
    bus.s_awaddr = 32'h0000_2008; bus.s_wdata = 32'h0BAD_F00D; bus.s_wstrb = 4'hF;
    bus.s_araddr = 32'h0000_1000;
    bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; bus.s_arvalid = 1'b1;
    @(negedge clk);
    chk("pri_awready", 32'(bus.s_awready), 32'(w_first));
    chk("pri_arready", 32'(bus.s_arready), 32'(!w_first));
    n = 0;
    while ((bus.s_awvalid || bus.s_arvalid || busy) && n < 100) begin
      gw = bus.s_awready; gr = bus.s_arready;
      @(posedge clk); #1;
      if (gw) begin bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; end
      if (gr) bus.s_arvalid = 1'b0;
      @(negedge clk); n++;
    end
    chk("pri_done", 32'(n < 100), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit hit, got no finish want finish");
    $fatal(1);
  end

  initial begin
    int         lat;
    logic [3:0] v1, vend, seen;
    rst = 1'b1; clear_stats = 1'b0; aw_en = '1;
    for (int i = 0; i < NS; i++) begin bdly[i] = 0; rdly[i] = 0; end
    bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
    bus.s_wvalid = 1'b0; bus.s_bready = 1'b1; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
    bus.s_rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bvalid", 32'(bus.s_bvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.s_rvalid), 32'd0);
    chk("rst_m_awvalid", 32'(bus.m_awvalid), 32'd0);
    chk("rst_m_arvalid", 32'(bus.m_arvalid), 32'd0);
    chk("rst_rdata", bus.s_rdata, 32'd0);
    chk("rst_m_awaddr", bus.m_awaddr, 32'd0);
    chk("rst_decerr", 32'(decerr_count), 32'd0);
    chk("rst_timeout", 32'(timeout_count), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    fork monitor(); join_none

    // zero-wait write to slave 2
    wr(32'h0000_2004, 32'hDEAD_BEEF, 4'hF, 2'b00, lat, v1, vend, seen);
    chk("w0_latency", 32'(lat), 32'd3);
    chk("w0_awvalid_c1", 32'(v1), 32'b0100);
    chk("w0_awvalid_any", 32'(seen), 32'b0100);
    chk("w0_awaddr", bus.m_awaddr, 32'h0000_2004);
    chk("w0_wdata", bus.m_wdata, 32'hDEAD_BEEF);
    chk("w0_wstrb", 32'(bus.m_wstrb), 32'hF);

    // read slave 1 with a 5-cycle rvalid delay
    rdly[1] = 5;
    rd(32'h0000_1010, 32'h1234_5678, 2'b00, lat, v1, seen);
    chk("r1_latency", 32'(lat), 32'd8);
    chk("r1_arvalid_any", 32'(seen), 32'b0010);
    chk("r1_araddr", bus.m_araddr, 32'h0000_1010);

    // unmapped read
    rd(32'h0000_8000, 32'h0, 2'b11, lat, v1, seen);
    chk("miss_latency", 32'(lat), 32'd1);
    chk("miss_arvalid_any", 32'(seen), 32'd0);
    chk("miss_decerr", 32'(decerr_count), 32'd1);

    // slave 0 never accepts the address
    aw_en[0] = 1'b0;
    wr(32'h0000_0040, 32'h5555_AAAA, 4'h3, 2'b10, lat, v1, vend, seen);
    chk("to_latency", 32'(lat), 32'd9);
    chk("to_awvalid_c1", 32'(v1), 32'b0001);
    chk("to_awvalid_end", 32'(vend), 32'd0);
    chk("to_count", 32'(timeout_count), 32'd1);
    aw_en[0] = 1'b1;

    // arbitration: first conflict -> write, second -> read
    rdly[1] = 0;
    pair(1'b1);
    pair(1'b0);

    // decerr saturation, then clear_stats against a simultaneous miss
    @(posedge clk); #1 force dut.decerr_q = 16'hFFFD;
    @(posedge clk); #1 release dut.decerr_q;
    chk("sat_preload", 32'(decerr_count), 32'hFFFD);
    rd(32'h0000_8000, 32'h0, 2'b11, lat, v1, seen);
    chk("sat_fffe", 32'(decerr_count), 32'hFFFE);
    rd(32'h0000_9000, 32'h0, 2'b11, lat, v1, seen);
    chk("sat_ffff", 32'(decerr_count), 32'hFFFF);
    rd(32'h0000_8000, 32'h0, 2'b11, lat, v1, seen);
    chk("sat_hold", 32'(decerr_count), 32'hFFFF);
    push(1'b1, 2'b11, 32'h0);
    @(posedge clk); #1;
    bus.s_araddr = 32'h0000_8000; bus.s_arvalid = 1'b1; clear_stats = 1'b1;
    @(negedge clk);
    chk("clr_grant", 32'(bus.s_arready), 32'd1);
    @(posedge clk); #1;
    bus.s_arvalid = 1'b0; clear_stats = 1'b0;
    @(negedge clk);
    chk("clr_wins", 32'(decerr_count), 32'd0);
    @(posedge clk);

    // reset in the middle of a delayed read aborts it
    rdly[1] = 5;
    @(posedge clk); #1;
    bus.s_araddr = 32'h0000_1000; bus.s_arvalid = 1'b1;
    @(negedge clk);
    chk("mr_grant", 32'(bus.s_arready), 32'd1);
    @(posedge clk); #1 bus.s_arvalid = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("mr_busy", 32'(busy), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("mr_busy_rst", 32'(busy), 32'd0);
    chk("mr_rready", 32'(bus.m_rready), 32'd0);
    chk("mr_rvalid", 32'(bus.s_rvalid), 32'd0);
    chk("mr_timeout_cnt", 32'(timeout_count), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    rdly[1] = 0;

    // recovery: zero-wait write to slave 3
    wr(32'h0000_3ffc, 32'h0102_0304, 4'h1, 2'b00, lat, v1, vend, seen);
    chk("rec_latency", 32'(lat), 32'd3);
    chk("rec_awvalid_c1", 32'(v1), 32'b1000);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axil_addr_router.md
# axil_addr_router

Parametrised AXI4-Lite 1-to-N address router sitting between the UART-AXI4 bridge master port and the system's register blocks and peripherals, generalising the current single-slave direct hookup. Decodes each transaction against a per-slave base/mask table, forwards it to one slave, and returns the response to the master. Unmapped addresses get DECERR and unresponsive slaves get SLVERR after a timeout. Saturating error counters feed the register block's status inputs.

## Interface
- NUM_SLAVES, 4, number of slave ports (1..16)
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (strobe width = DATA_WIDTH/8)
- SLAVE_BASE, {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}, packed NUM_SLAVES*ADDR_WIDTH; slice i = base of slave i
- SLAVE_MASK, all slices 32'hFFFF_F000, packed; slice i = significant-bit mask of slave i
- TIMEOUT_CYCLES, 1000, cycles waited for slave handshake/response (>=2)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_WIDTH/1/1  master write address
- s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  master write data
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  master write response
- s_araddr/s_arvalid/s_arready  in/in/out  ADDR_WIDTH/1/1  master read address
- s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  DATA_WIDTH/2/1/1  master read data
- m_awaddr, m_wdata, m_wstrb, m_araddr  out  shared  registered copies broadcast to all slaves
- m_awvalid/m_wvalid/m_bready/m_arvalid/m_rready  out  NUM_SLAVES each  per-slave, one-hot or zero
- m_awready/m_wready/m_bvalid/m_arready/m_rvalid  in  NUM_SLAVES each  per-slave
- m_bresp/m_rresp  in  2*NUM_SLAVES each  packed per-slave
- m_rdata  in  DATA_WIDTH*NUM_SLAVES  packed per-slave
- clear_stats  in  1  one-cycle pulse, zeroes counters
- busy  out  1  state != IDLE
- decerr_count/timeout_count  out  16 each  saturating at 16'hFFFF

## Operation
- One outstanding transaction. FSM states: IDLE, W_ISSUE, W_RESP, W_RET, R_ISSUE, R_RESP, R_RET.
- Write pending = s_awvalid && s_wvalid. Read pending = s_arvalid. If both are pending, grant goes opposite to last_grant. last_grant resets to READ, so the first conflict grants the write.
- Grant (in IDLE only, combinational): write asserts s_awready and s_wready together. Read asserts s_arready. Address, data and strobe are captured that cycle.
- Decode at capture: slave i hits if (addr & MASK[i]) == (BASE[i] & MASK[i]). The lowest hitting index wins. Stores sel and hit.
- Write, hit: W_ISSUE asserts m_awvalid[sel] and m_wvalid[sel]. Each valid drops independently after its own handshake.
  - When both handshakes are done, go to W_RESP: m_bready[sel]=1; capture m_bresp[sel] on m_bvalid[sel].
  - Then W_RET: s_bvalid=1 with the captured bresp, held until s_bready; then IDLE.
- Write, miss: go directly to W_RET with bresp=2'b11; decerr_count increments.
- Reads mirror writes (R_ISSUE/R_RESP/R_RET) and capture m_rdata[sel] and m_rresp[sel]. On a miss, rdata=0 and rresp=2'b11.
- Timeout: counter clears on grant and counts each cycle in ISSUE/RESP states. On reaching TIMEOUT_CYCLES:
  - all m_* valid/ready drop;
  - go to *_RET with resp=2'b10 (rdata=0);
  - timeout_count increments.
  - Late responses from that slave are ignored. Documented limitation: the slave may stay blocked until the next access.
- Counters: clear_stats wins over a simultaneous increment. Both counters stop at 16'hFFFF.

## Timing
- Reset values: every s_*ready/valid and m_*valid/ready = 0; s_bresp, s_rresp, s_rdata, m_* payloads = 0; counters = 0; busy = 0; state = IDLE.
- Reset mid-transaction aborts it. All outputs hold reset values on the cycle after rst is sampled high.
- Zero-wait slave: grant at cycle 0; m_awvalid/m_wvalid high at cycle 1 and accepted at 1; m_bvalid at 2, captured; s_bvalid at 3. Read latency is identical. Miss: s_bvalid/s_rvalid at cycle 1.
- The master's valids may stay high after the response; a new grant happens only in IDLE, one cycle after *_RET completes.
- Payload registers are stable from cycle 1 until the next grant.

## Test plan
- Write 0x0000_2004 data 0xDEADBEEF strb 0xF, zero-wait slaves -> only m_awvalid[2] asserts, at cycle 1; s_bvalid=1, bresp=00 at cycle 3.
- Read 0x0000_1010, slave 1 returns 0x12345678 after a 5-cycle rvalid delay -> s_rdata=0x12345678, rresp=00; no other m_arvalid bit toggles.
- Read 0x0000_8000 (unmapped) -> s_rvalid at cycle 1, rresp=11, rdata=0; decerr_count 0->1; no m_arvalid asserts.
- TIMEOUT_CYCLES=8, slave 0 never asserts awready -> m_awvalid[0] drops and s_bresp=10 after 8 cycles; timeout_count=1.
- AR and AW+W asserted in the same cycle after reset -> write granted first, read second; a second simultaneous pair -> read first.
- Force decerr_count to 0xFFFF via repeated misses -> stays 0xFFFF; clear_stats pulsed together with a miss -> 0x0000.
